// File: rtl/led_matrix_scanner_if.sv
// LED matrix driver pins of led_matrix_scanner.
//   SER_DATA   serial column data, valid across the whole bit slot
//   SER_CLK    shift clock; drivers sample SER_DATA on its rising edge
//   LATCH      one-cycle transfer pulse into the driver output register
//   ROW_SEL    active row index
//   ROW_EN     row driver enable
//   FRAME_DONE one-cycle pulse after the last row's dwell
// master: scanner side (drives the pins); slave: board/driver side.
interface led_matrix_scanner_if;
    logic       SER_DATA;
    logic       SER_CLK;
    logic       LATCH;
    logic [3:0] ROW_SEL;
    logic       ROW_EN;
    logic       FRAME_DONE;

    modport master (
        output SER_DATA, SER_CLK, LATCH, ROW_SEL, ROW_EN, FRAME_DONE
    );

    modport slave (
        input SER_DATA, SER_CLK, LATCH, ROW_SEL, ROW_EN, FRAME_DONE
    );
endinterface

// File: rtl/led_matrix_scanner.sv
// Scans a 16x16 red/green frame out to shift-register column drivers.
// The frame is snapshotted once per frame, then each row's 32 column bits
// are shifted out MSB first (red col 15 .. red col 0, green col 15 .. green
// col 0), latched, and the row is enabled for DWELL cycles.
//
// Ports:
//   CLK        system clock
//   RST        asynchronous active-low reset
//   ENABLE     scanning permitted; looked at only in IDLE and at frame end
//   RedPixels  red frame, RedPixels[row][col]
//   GrnPixels  green frame, same indexing
//   pins       driver pins (see led_matrix_scanner_if), master side
//
// state     | meaning
// ----------+-------------------------------------------------------
// S_IDLE    | not scanning, all outputs at reset values
// S_SNAP    | capture both pixel arrays, start row 0
// S_SHIFT   | serialize 32 bits of row r, 2*SHIFT_HALF cycles per bit
// S_LATCH   | one-cycle LATCH pulse, ROW_SEL takes row r
// S_DISPLAY | ROW_EN high for DWELL cycles, then next row or frame end
module led_matrix_scanner #(
    parameter int SHIFT_HALF = 2,
    parameter int DWELL      = 256
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ENABLE,
    input  logic [15:0][15:0]     RedPixels,
    input  logic [15:0][15:0]     GrnPixels,
    led_matrix_scanner_if.master  pins
);

    localparam int SLOT = 2 * SHIFT_HALF;
    localparam int MAXV = (SLOT > DWELL) ? SLOT : DWELL;
    // Timer only ever holds values up to MAXV-1, so it cannot wrap.
    localparam int TW   = (MAXV > 1) ? $clog2(MAXV) : 1;

    localparam logic [TW-1:0] SLOT_LAST  = TW'(SLOT - 1);
    localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL - 1);
    localparam logic [TW-1:0] HALF_T     = TW'(SHIFT_HALF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SNAP,
        S_SHIFT,
        S_LATCH,
        S_DISPLAY
    } state_t;

    state_t           state_q;
    logic [15:0][15:0] red_buf_q;
    logic [15:0][15:0] grn_buf_q;
    logic [3:0]       row_q;
    logic [4:0]       bit_q;
    logic [TW-1:0]    tmr_q;
    logic [31:0]      word_q;     // bits still to send, next one at [31]
    logic             ser_data_q;
    logic             ser_clk_q;
    logic             latch_q;
    logic [3:0]       row_sel_q;
    logic             row_en_q;
    logic             frame_done_q;
    logic [3:0]       row_nxt;

    assign row_nxt = row_q + 4'd1;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            red_buf_q    <= '0;
            grn_buf_q    <= '0;
            row_q        <= '0;
            bit_q        <= '0;
            tmr_q        <= '0;
            word_q       <= '0;
            ser_data_q   <= 1'b0;
            ser_clk_q    <= 1'b0;
            latch_q      <= 1'b0;
            row_sel_q    <= '0;
            row_en_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            latch_q      <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ser_data_q <= 1'b0;
                    ser_clk_q  <= 1'b0;
                    row_en_q   <= 1'b0;
                    row_sel_q  <= '0;
                    if (ENABLE) state_q <= S_SNAP;
                end
                S_SNAP: begin
                    red_buf_q  <= RedPixels;
                    grn_buf_q  <= GrnPixels;
                    row_q      <= '0;
                    // Row 0 is loaded straight from the inputs being
                    // captured this cycle, so it matches the snapshot.
                    ser_data_q <= RedPixels[0][15];
                    word_q     <= {RedPixels[0][14:0], GrnPixels[0], 1'b0};
                    bit_q      <= 5'd31;
                    tmr_q      <= SLOT_LAST;
                    ser_clk_q  <= 1'b0;
                    state_q    <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (tmr_q != '0) begin
                        // Timer counts SLOT-1 down to 0; the last
                        // SHIFT_HALF counts of a slot are the high phase.
                        tmr_q     <= tmr_q - 1'b1;
                        ser_clk_q <= (tmr_q <= HALF_T);
                    end else if (bit_q != '0) begin
                        bit_q      <= bit_q - 1'b1;
                        tmr_q      <= SLOT_LAST;
                        ser_clk_q  <= 1'b0;
                        ser_data_q <= word_q[31];
                        word_q     <= {word_q[30:0], 1'b0};
                    end else begin
                        ser_clk_q  <= 1'b0;
                        ser_data_q <= 1'b0;
                        latch_q    <= 1'b1;
                        row_sel_q  <= row_q;
                        state_q    <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    row_en_q <= 1'b1;
                    tmr_q    <= DWELL_LAST;
                    state_q  <= S_DISPLAY;
                end
                S_DISPLAY: begin
                    if (tmr_q != '0) begin
                        tmr_q <= tmr_q - 1'b1;
                    end else begin
                        row_en_q <= 1'b0;
                        if (row_q != 4'd15) begin
                            row_q      <= row_nxt;
                            ser_data_q <= red_buf_q[row_nxt][15];
                            word_q     <= {red_buf_q[row_nxt][14:0],
                                           grn_buf_q[row_nxt], 1'b0};
                            bit_q      <= 5'd31;
                            tmr_q      <= SLOT_LAST;
                            state_q    <= S_SHIFT;
                        end else begin
                            frame_done_q <= 1'b1;
                            if (ENABLE) begin
                                state_q <= S_SNAP;
                            end else begin
                                row_sel_q <= '0;
                                state_q   <= S_IDLE;
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pins.SER_DATA   = ser_data_q;
    assign pins.SER_CLK    = ser_clk_q;
    assign pins.LATCH      = latch_q;
    assign pins.ROW_SEL    = row_sel_q;
    assign pins.ROW_EN     = row_en_q;
    assign pins.FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench for led_matrix_scanner with default parameters.
// A timing/frame model predicts every output per cycle from the frame
// start time; directed and random frames exercise it.
module tb_led_matrix_scanner;

    localparam int SHIFT_HALF = 2;
    localparam int DWELL      = 256;
    localparam int SLOT       = 2 * SHIFT_HALF;
    localparam int SHIFT_LEN  = 64 * SHIFT_HALF;
    localparam int ROW_P      = SHIFT_LEN + 1 + DWELL;
    localparam int FRAME_P    = 1 + 16 * ROW_P;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              ENABLE = 1'b0;
    logic [15:0][15:0] RedPixels;
    logic [15:0][15:0] GrnPixels;

    led_matrix_scanner_if pins ();

    led_matrix_scanner #(
        .SHIFT_HALF (SHIFT_HALF),
        .DWELL      (DWELL)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .ENABLE    (ENABLE),
        .RedPixels (RedPixels),
        .GrnPixels (GrnPixels),
        .pins      (pins)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- reference model + monitor (negedge) ----------------
    logic [15:0] m_red [16];
    logic [15:0] m_grn [16];
    bit          m_active = 0;
    int          m_snap   = 0;
    int          m_fd_cyc = -1;
    int          d, r, k;
    logic [31:0] w;
    logic        e_clk, e_latch, e_en, e_fd;

    logic        prev_clk = 1'b0;
    logic [31:0] cap = '0;
    logic [31:0] cap_word [16];
    int          latch_cyc [16];
    int          first_rise_row [16];
    int          en_cnt [16];
    int          first_rise_cyc = 0;
    int          rise_n = 0;
    int          rise_total = 0;
    int          fd_count = 0;

    always @(negedge CLK) begin
        if (!RST) begin
            check("rst_outputs",
                  32'({pins.SER_DATA, pins.SER_CLK, pins.LATCH, pins.ROW_EN,
                       pins.FRAME_DONE, pins.ROW_SEL}), 32'd0);
            m_active = 0;
            m_fd_cyc = -1;
            prev_clk = 1'b0;
            rise_n   = 0;
        end else begin
            e_clk   = 1'b0;
            e_latch = 1'b0;
            e_en    = 1'b0;
            e_fd    = (cyc == m_fd_cyc);
            if (m_active) begin
                d = cyc - m_snap;
                if (d == 0) begin
                    for (int i = 0; i < 16; i++) begin
                        m_red[i] = RedPixels[i];
                        m_grn[i] = GrnPixels[i];
                    end
                end else begin
                    r = (d - 1) / ROW_P;
                    k = (d - 1) % ROW_P;
                    w = {m_red[r], m_grn[r]};
                    if (k < SHIFT_LEN) begin
                        e_clk = ((k % SLOT) >= SHIFT_HALF);
                        check("ser_data", 32'(pins.SER_DATA), 32'(w[31 - k / SLOT]));
                    end else if (k == SHIFT_LEN) begin
                        e_latch = 1'b1;
                        check("latch_row_sel", 32'(pins.ROW_SEL), 32'(r));
                    end else begin
                        e_en = 1'b1;
                        check("dwell_row_sel", 32'(pins.ROW_SEL), 32'(r));
                    end
                end
                if (d == FRAME_P - 1) begin
                    m_fd_cyc = cyc + 1;
                    if (ENABLE) m_snap = cyc + 1;
                    else        m_active = 0;
                end
            end else begin
                check("idle_ser_data", 32'(pins.SER_DATA), 32'd0);
                check("idle_row_sel", 32'(pins.ROW_SEL), 32'd0);
                if (ENABLE) begin
                    m_active = 1;
                    m_snap   = cyc + 1;
                end
            end
            check("ser_clk", 32'(pins.SER_CLK), 32'(e_clk));
            check("latch", 32'(pins.LATCH), 32'(e_latch));
            check("row_en", 32'(pins.ROW_EN), 32'(e_en));
            check("frame_done", 32'(pins.FRAME_DONE), 32'(e_fd));

            if (!prev_clk && pins.SER_CLK) begin
                cap = {cap[30:0], pins.SER_DATA};
                if (rise_n == 0) first_rise_cyc = cyc;
                rise_n++;
                rise_total++;
            end
            if (pins.LATCH) begin
                cap_word[pins.ROW_SEL]       = cap;
                latch_cyc[pins.ROW_SEL]      = cyc;
                first_rise_row[pins.ROW_SEL] = first_rise_cyc;
                en_cnt[pins.ROW_SEL]         = 0;
                rise_n = 0;
            end
            if (pins.ROW_EN) en_cnt[pins.ROW_SEL]++;
            if (pins.FRAME_DONE) fd_count++;
            prev_clk = pins.SER_CLK;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_fd(output int at);
        at = -1;
        for (int i = 0; i < FRAME_P + 50; i++) begin
            @(posedge CLK);
            #2;
            if (pins.FRAME_DONE) begin
                at = cyc;
                break;
            end
        end
        check("frame_done_seen", 32'(at >= 0), 32'd1);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    int          t_snap, f1, f2, f3, f4, f5, f6, t_rst, found, rises0, fd0;
    logic [15:0] x_red [16];
    logic [15:0] x_grn [16];

    initial begin
        RedPixels = '0;
        GrnPixels = '0;
        step(3);
        RST = 1'b1;

        // idle with ENABLE low: no shift clock activity at all
        step(100);
        check("idle_no_ser_clk", 32'(rise_total), 32'd0);

        // frame 1: single red pixel at row 0, column 15
        RedPixels[0][15] = 1'b1;
        ENABLE = 1'b1;
        t_snap = cyc + 1;
        step(1000);
        // bit-order data for frame 2, invisible to frame 1
        RedPixels = '0;
        GrnPixels[5] = 16'hA5A5;
        wait_fd(f1);
        check("f1_period", 32'(f1 - t_snap), 32'(FRAME_P));
        check("f1_first_rise", 32'(first_rise_row[0] - t_snap), 32'd3);
        check("f1_latch_cyc", 32'(latch_cyc[0] - t_snap), 32'd129);
        check("f1_row0_word", cap_word[0], 32'h8000_0000);
        check("f1_row0_dwell", 32'(en_cnt[0]), 32'(DWELL));
        for (int i = 1; i < 16; i++) check("f1_row_word", cap_word[i], 32'd0);

        // frame 2: green row 5 = A5A5
        wait_fd(f2);
        check("f2_row5_word", cap_word[5], 32'h0000_A5A5);
        check("f2_row5_latch", 32'(latch_cyc[5] - f1), 32'(1 + 5 * ROW_P + SHIFT_LEN));
        check("f2_row4_word", cap_word[4], 32'd0);

        // frame 3: change green to all ones while row 3 is shifting
        step(1 + 3 * ROW_P + 20);
        for (int i = 0; i < 16; i++) GrnPixels[i] = 16'hFFFF;
        wait_fd(f3);
        for (int i = 3; i < 16; i++)
            check("f3_isolated", cap_word[i], (i == 5) ? 32'h0000_A5A5 : 32'd0);

        // frame 4 sees the new green; frame 5 gets random data set now
        for (int i = 0; i < 16; i++) begin
            x_red[i] = 16'($urandom);
            x_grn[i] = 16'($urandom);
        end
        wait_fd(f4);
        for (int i = 0; i < 16; i++) check("f4_row_word", cap_word[i], 32'h0000_FFFF);
        for (int i = 0; i < 16; i++) begin
            RedPixels[i] = x_red[i];
            GrnPixels[i] = x_grn[i];
        end

        // frame 5: random data, then a random mid-frame change (frame 6)
        step($urandom_range(50, FRAME_P - 200));
        for (int i = 0; i < 16; i++) begin
            RedPixels[i] = 16'($urandom);
            GrnPixels[i] = 16'($urandom);
        end
        wait_fd(f5);
        for (int i = 0; i < 16; i++)
            check("f5_row_word", cap_word[i], {x_red[i], x_grn[i]});

        // frame 6: drop ENABLE mid-frame; frame still completes
        step($urandom_range(50, FRAME_P - 200));
        ENABLE = 1'b0;
        wait_fd(f6);
        for (int i = 0; i < 16; i++)
            check("f6_row_word", cap_word[i], {RedPixels[i], GrnPixels[i]});
        check("cadence_2", 32'(f2 - f1), 32'(FRAME_P));
        check("cadence_3", 32'(f3 - f2), 32'(FRAME_P));
        check("cadence_4", 32'(f4 - f3), 32'(FRAME_P));
        check("cadence_5", 32'(f5 - f4), 32'(FRAME_P));
        check("cadence_6", 32'(f6 - f5), 32'(FRAME_P));
        rises0 = rise_total;
        step(60);
        check("post_disable_idle", 32'(rise_total - rises0), 32'd0);

        // restart, reset asynchronously during row 7 dwell
        ENABLE = 1'b1;
        found = 0;
        for (int i = 0; i < 2 * FRAME_P; i++) begin
            step(1);
            if (pins.ROW_EN && pins.ROW_SEL == 4'd7) begin
                found = 1;
                break;
            end
        end
        check("row7_dwell_seen", 32'(found), 32'd1);
        fd0 = fd_count;
        RST = 1'b0;
        #1;
        check("rst_async_row_en", 32'(pins.ROW_EN), 32'd0);
        step(3);
        RST = 1'b1;
        t_rst = cyc + 1;
        step(200);
        check("restart_latch_cyc", 32'(latch_cyc[0] - t_rst), 32'd129);
        check("restart_row0_word", cap_word[0], {RedPixels[0], GrnPixels[0]});
        check("no_fd_on_abort", 32'(fd_count - fd0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/led_matrix_scanner.md
Name: led_matrix_scanner

Overview:
- Consumer of the 16x16 RedPixels/GrnPixels frame produced by the pattern and game logic.
- Snapshots both pixel arrays at each frame start and scans the frame out one row at a time.
- Each row's 32 column bits are serialized into external shift-register column drivers, latched, then the row is enabled for a fixed dwell time.
- Sits between the game/pattern generators and the board's LED matrix pins.

Parameters:
- SHIFT_HALF, 2: cycles per SER_CLK half-period (each bit takes 2*SHIFT_HALF cycles); must be >= 1.
- DWELL, 256: cycles ROW_EN stays high per row; must be >= 1.

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous, active-low reset.
- ENABLE  input  1  scanning permitted; sampled only in IDLE and at frame end.
- RedPixels  input  [15:0][15:0]  red frame; RedPixels[r][c] is row r, column c.
- GrnPixels  input  [15:0][15:0]  green frame, same indexing.
- SER_DATA  output  1  serial column data to drivers.
- SER_CLK  output  1  shift clock; drivers sample SER_DATA on its rising edge.
- LATCH  output  1  one-cycle pulse that transfers the shifted word to driver outputs.
- ROW_SEL  output  4  active row index.
- ROW_EN  output  1  row driver enable.
- FRAME_DONE  output  1  one-cycle pulse after the last row's dwell completes.

Behaviour:
- Reset (RST=0, asynchronous): state IDLE; SER_DATA=0, SER_CLK=0, LATCH=0, ROW_EN=0, ROW_SEL=0, FRAME_DONE=0; snapshot buffer cleared to 0. Reset mid-frame aborts immediately with ROW_EN forced to 0 and no FRAME_DONE.
- States: IDLE, SNAP, SHIFT, LATCH, DISPLAY.
- IDLE: all outputs at reset values. If ENABLE=1, go to SNAP next cycle.
- SNAP (1 cycle):
  - Register all 512 pixel bits into an internal frame buffer.
  - Set row counter to 0, then go to SHIFT.
  - Input changes after SNAP are invisible until the next SNAP (no tearing).
- SHIFT:
  - ROW_EN=0 throughout.
  - Shifted word is {buf_red[r], buf_grn[r]} (32 bits), sent MSB first: red col 15 first, green col 0 last.
  - Per bit: SER_DATA is set to the bit on the first cycle of the slot and held for the whole slot. SER_CLK=0 for SHIFT_HALF cycles, then 1 for SHIFT_HALF cycles.
  - SHIFT lasts 64*SHIFT_HALF cycles. SER_CLK returns to 0 on leaving.
- LATCH (1 cycle): LATCH=1, ROW_SEL updates to r, SER_CLK=0, ROW_EN=0.
- DISPLAY: ROW_EN=1 for exactly DWELL cycles, ROW_SEL=r. On the last cycle:
  - if r<15: r increments, next state SHIFT;
  - if r=15: next state SNAP if ENABLE=1, else IDLE.
- FRAME_DONE: asserted for exactly the cycle after row 15's last DISPLAY cycle. That cycle is SNAP or IDLE.
- ENABLE deassert mid-frame: the current frame completes and FRAME_DONE still pulses; then the block enters IDLE.
- Timing with defaults:
  - Row period = 64*SHIFT_HALF + 1 + DWELL = 385 cycles.
  - Frame period under continuous ENABLE = 1 + 16*385 = 6161 cycles.
- ROW_EN and LATCH are never high in the same cycle. ROW_EN is never high during SHIFT.
- Counter widths: sized from parameters. No wrap-around may occur within a slot or dwell for any legal parameter value.

Test Plan:
- Reset/idle: RST=0 then RST=1 with ENABLE=0 for 100 cycles -> all outputs 0, no SER_CLK edges.
- Single-pixel frame: RedPixels[0][15]=1, all else 0, ENABLE=1 -> row 0 word shifts 1 then 31 zeros. First rising SER_CLK is at cycle 1+2 after SNAP entry. LATCH pulses at SNAP+129 with ROW_SEL=0. ROW_EN is high for 256 cycles.
- Bit ordering: GrnPixels[5]=16'hA5A5, RedPixels[5]=16'h0000 -> row 5 serial capture (sampled on SER_CLK rising edges) equals 32'h0000A5A5. The LATCH pulse for row 5 occurs with ROW_SEL=5.
- Snapshot isolation: change all GrnPixels to 16'hFFFF while row 3 is shifting -> rows 3..15 of the current frame still show the old data. The next frame shows 16'hFFFF.
- Frame cadence: continuous ENABLE=1 with defaults -> FRAME_DONE pulses are exactly 6161 cycles apart, each 1 cycle wide. ROW_SEL sequences 0..15.
- Reset mid-DISPLAY: assert RST=0 while ROW_EN=1 on row 7 -> ROW_EN=0 in the same cycle (asynchronous). After release with ENABLE=1, scanning restarts at SNAP with row 0.
